// File: rtl/sync_up_counter.sv
// sync_up_counter: run-controlled up counter stepped by a slow tick.
// Keys and tick are synchronized; load > stop > start > step per clk.
module sync_up_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             start_n,
  input  logic             stop_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             wrap,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             running
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic tick_s1, tick_s2, tick_prev;
  logic start_s1, start_s2, start_prev;
  logic stop_s1, stop_s2, stop_prev;
  logic [1:0] warm_q;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_d;
  logic             tc_d;

  logic step, start_evt, stop_evt, keys_ok;

  // Two-flop synchronizers plus edge-detect history, idle levels on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_s1    <= 1'b0;
      tick_s2    <= 1'b0;
      tick_prev  <= 1'b0;
      start_s1   <= 1'b1;
      start_s2   <= 1'b1;
      start_prev <= 1'b1;
      stop_s1    <= 1'b1;
      stop_s2    <= 1'b1;
      stop_prev  <= 1'b1;
    end else begin
      tick_s1    <= tick;
      tick_s2    <= tick_s1;
      tick_prev  <= tick_s2;
      start_s1   <= start_n;
      start_s2   <= start_s1;
      start_prev <= start_s2;
      stop_s1    <= stop_n;
      stop_s2    <= stop_s1;
      stop_prev  <= stop_s2;
    end
  end

  // Key edges count only once the history holds real samples, so a
  // key already held low across reset release is not seen as a press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      warm_q <= 2'd0;
    end else if (warm_q != 2'd3) begin
      warm_q <= warm_q + 2'd1;
    end
  end

  assign keys_ok   = (warm_q == 2'd3);
  assign step      = tick_s2 & ~tick_prev;
  assign start_evt = keys_ok & ~start_s2 & start_prev;
  assign stop_evt  = keys_ok & ~stop_s2 & stop_prev;

  // Resolve load/stop/start/step in priority order into next state.
  always_comb begin
    state_d = state_q;
    count_d = count;
    tc_d    = 1'b0;
    if (load) begin
      count_d = (load_val > MAX_V) ? MAX_V : load_val;
      state_d = IDLE;
    end else if (stop_evt) begin
      state_d = IDLE;
    end else if (start_evt && state_q != RUN) begin
      state_d = RUN;
      if (state_q == DONE) begin
        count_d = '0;
      end
    end else if (step && state_q == RUN) begin
      if (count != MAX_V) begin
        count_d = count + ONE;
      end else begin
        tc_d = 1'b1;
        if (wrap) begin
          count_d = '0;
        end else begin
          state_d = DONE;
        end
      end
    end
  end

  // Registered state, count and terminal-count pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count   <= '0;
      tc      <= 1'b0;
    end else begin
      state_q <= state_d;
      count   <= count_d;
      tc      <= tc_d;
    end
  end

  assign running = (state_q == RUN);

endmodule

// File: tb/tb_sync_up_counter.sv
// tb_sync_up_counter: directed scenarios plus random stimulus,
// checked every cycle against a sample-history reference model.
module tb_sync_up_counter;

  localparam int W  = 5;
  localparam int MX = 15;

  logic         clk = 1'b0;
  logic         reset;
  logic         tick;
  logic         start_n;
  logic         stop_n;
  logic         load;
  logic [W-1:0] load_val;
  logic         wrap;
  logic [W-1:0] count;
  logic         tc;
  logic         running;

  sync_up_counter #(.WIDTH(W), .MAX(MX)) dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .start_n  (start_n),
    .stop_n   (stop_n),
    .load     (load),
    .load_val (load_val),
    .wrap     (wrap),
    .count    (count),
    .tc       (tc),
    .running  (running)
  );

  always #5 clk = ~clk;

  typedef enum int {M_IDLE, M_RUN, M_DONE} mode_t;

  mode_t m_mode;
  int    m_count;
  int    m_tc;
  int    h_tick[3];
  int    h_start[3];
  int    h_stop[3];
  int    n_pass = 0;
  int    n_tot = 0;
  int    tc_seen = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  nm, act, exp, $time);
  endtask

  // -1 marks a key sample not taken since reset: no edge can use it
  task automatic m_reset();
    m_mode  = M_IDLE;
    m_count = 0;
    m_tc    = 0;
    for (int i = 0; i < 3; i++) begin
      h_tick[i]  = 0;
      h_start[i] = -1;
      h_stop[i]  = -1;
    end
  endtask

  function automatic bit fell(input int now_v, input int old_v);
    return now_v == 0 && old_v == 1;
  endfunction

  // inputs sampled at edge m act at edge m+2 (two sync stages)
  task automatic m_edge();
    bit st, sa, sp;
    int lv;
    st = (h_tick[1] == 1) && (h_tick[2] == 0);
    sa = fell(h_start[1], h_start[2]);
    sp = fell(h_stop[1], h_stop[2]);
    m_tc = 0;
    if (load) begin
      lv = int'(load_val);
      m_count = (lv > MX) ? MX : lv;
      m_mode = M_IDLE;
    end else if (sp) begin
      m_mode = M_IDLE;
    end else if (sa && m_mode != M_RUN) begin
      if (m_mode == M_DONE) m_count = 0;
      m_mode = M_RUN;
    end else if (st && m_mode == M_RUN) begin
      if (m_count < MX) begin
        m_count = m_count + 1;
      end else begin
        m_tc = 1;
        if (wrap) m_count = 0;
        else m_mode = M_DONE;
      end
    end
    for (int i = 2; i > 0; i--) begin
      h_tick[i]  = h_tick[i-1];
      h_start[i] = h_start[i-1];
      h_stop[i]  = h_stop[i-1];
    end
    h_tick[0]  = int'(tick);
    h_start[0] = int'(start_n);
    h_stop[0]  = int'(stop_n);
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) m_reset();
      else m_edge();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("count", int'(count), m_count);
      chk("tc", int'(tc), m_tc);
      chk("running", int'(running), int'(m_mode == M_RUN));
      if (tc) tc_seen++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press_start();
    start_n = 1'b0;
    cyc(3);
    start_n = 1'b1;
    cyc(1);
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    cyc(3);
    tick = 1'b0;
    cyc(3);
  endtask

  task automatic do_load(input int v);
    load_val = W'(v);
    load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  initial begin
    bit rp;
    reset    = 1'b0;
    tick     = 1'b0;
    start_n  = 1'b1;
    stop_n   = 1'b1;
    load     = 1'b0;
    load_val = '0;
    wrap     = 1'b1;

    for (int i = 0; i < 8; i++) begin
      cyc(1);
      tick    = ~tick;
      start_n = i[0];
      stop_n  = ~i[1];
    end
    tick = 1'b0;
    start_n = 1'b1;
    stop_n = 1'b1;
    @(negedge clk);
    chk("rst_count", int'(count), 0);
    chk("rst_running", int'(running), 0);
    cyc(1);
    reset = 1'b1;
    cyc(6);
    @(negedge clk);
    chk("idle_after_release", int'(running), 0);

    cyc(1);
    start_n = 1'b0;
    cyc(2);
    @(negedge clk);
    chk("start_lat_early", int'(running), 0);
    cyc(1);
    @(negedge clk);
    chk("start_lat_k2", int'(running), 1);
    cyc(1);
    start_n = 1'b1;
    tick = 1'b1;
    cyc(2);
    @(negedge clk);
    chk("step_lat_early", int'(count), 0);
    cyc(1);
    @(negedge clk);
    chk("step_lat_k2", int'(count), 1);
    cyc(1);
    tick = 1'b0;
    cyc(3);
    repeat (4) tick_pulse();
    @(negedge clk);
    chk("run_count5", int'(count), 5);

    cyc(1);
    wrap = 1'b1;
    do_load(14);
    @(negedge clk);
    chk("load14", int'(count), 14);
    chk("load_idle", int'(running), 0);
    cyc(1);
    press_start();
    cyc(4);
    tc_seen = 0;
    tick_pulse();
    @(negedge clk);
    chk("wrap_15", int'(count), 15);
    cyc(1);
    tick_pulse();
    cyc(2);
    @(negedge clk);
    chk("wrap_0", int'(count), 0);
    chk("wrap_tc_once", tc_seen, 1);
    chk("wrap_running", int'(running), 1);

    cyc(1);
    wrap = 1'b0;
    do_load(14);
    press_start();
    cyc(4);
    tc_seen = 0;
    repeat (3) tick_pulse();
    cyc(2);
    @(negedge clk);
    chk("sat_count", int'(count), 15);
    chk("sat_running", int'(running), 0);
    chk("sat_tc_once", tc_seen, 1);
    cyc(1);
    press_start();
    cyc(3);
    @(negedge clk);
    chk("done_restart_cnt", int'(count), 0);
    chk("done_restart_run", int'(running), 1);

    cyc(1);
    repeat (2) tick_pulse();
    tick = 1'b1;
    stop_n = 1'b0;
    cyc(6);
    tick = 1'b0;
    stop_n = 1'b1;
    cyc(4);
    @(negedge clk);
    chk("stop_step_cnt", int'(count), 2);
    chk("stop_step_run", int'(running), 0);
    cyc(1);
    load_val = W'(20);
    start_n = 1'b0;
    cyc(2);
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    cyc(2);
    start_n = 1'b1;
    cyc(4);
    @(negedge clk);
    chk("load_start_cnt", int'(count), 15);
    chk("load_start_run", int'(running), 0);

    cyc(1);
    do_load(9);
    press_start();
    cyc(4);
    @(negedge clk);
    chk("pre_rst_cnt", int'(count), 9);
    chk("pre_rst_run", int'(running), 1);
    cyc(1);
    start_n = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    #2;
    chk("mid_rst_cnt", int'(count), 0);
    chk("mid_rst_run", int'(running), 0);
    #1 reset = 1'b1;
    cyc(8);
    @(negedge clk);
    chk("held_key_no_start", int'(running), 0);
    cyc(1);
    start_n = 1'b1;
    cyc(4);

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      rp = ($urandom_range(0, 399) == 0);
      if (rp) reset = 1'b0;
      #1;
      if ($urandom_range(0, 2) == 0) tick = ~tick;
      if (start_n) start_n = ($urandom_range(0, 19) != 0);
      else start_n = ($urandom_range(0, 3) == 0);
      if (stop_n) stop_n = ($urandom_range(0, 39) != 0);
      else stop_n = ($urandom_range(0, 3) == 0);
      load = ($urandom_range(0, 49) == 0);
      load_val = W'($urandom_range(0, 31));
      if ($urandom_range(0, 29) == 0) wrap = ~wrap;
      if (rp) begin
        #2 reset = 1'b1;
      end
    end

    cyc(4);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
